noc_output_sink: RTL

Parametrised NoC endpoint sink that terminates one router output port. It accepts AXI-Stream flits into a DEPTH-entry first-word-fall-through buffer, tracks packet boundaries with a small FSM, and counts completed packets per TID channel. It presents buffered flits to the local consumer over a valid/ready port. Unlike the previous-generation sink, it applies real backpressure, preserves TLAST/TID, and never drops accepted data.

---
 rtl/noc_output_sink_pkg.sv | 21 ++
 rtl/noc_output_sink_if.sv | 31 +++
 rtl/noc_output_sink_fifo.sv | 63 ++++++
 rtl/noc_output_sink.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/noc_output_sink_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_output_sink_pkg
// Brief    : Shared types and helpers for the NoC output sink.
// Revision : 1.0 - initial release
// ============================================================================
package noc_output_sink_pkg;

    // Packet-boundary tracker states
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } sink_state_e;

    // Number of TID channels for a given TID width
    function automatic int ids_of(input int tidw);
        return 2 ** tidw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/noc_output_sink_if.sv
`default_nettype none
// ============================================================================
// Module   : noc_output_sink_if
// Brief    : AXI-Stream upstream port (router output -> sink input).
// Revision : 1.0 - initial release
// ============================================================================
interface noc_output_sink_if #(
    parameter int TDATAW = 32,
    parameter int TDESTW = 4,
    parameter int TIDW   = 2
);
    logic              AXIS_S_TVALID;
    logic              AXIS_S_TREADY;
    logic [TDATAW-1:0] AXIS_S_TDATA;
    logic              AXIS_S_TLAST;
    logic [TIDW-1:0]   AXIS_S_TID;
    logic [TDESTW-1:0] AXIS_S_TDEST;

    // Upstream (router) side
    modport master (
        output AXIS_S_TVALID, AXIS_S_TDATA, AXIS_S_TLAST, AXIS_S_TID, AXIS_S_TDEST,
        input  AXIS_S_TREADY
    );

    // Sink side
    modport slave (
        input  AXIS_S_TVALID, AXIS_S_TDATA, AXIS_S_TLAST, AXIS_S_TID, AXIS_S_TDEST,
        output AXIS_S_TREADY
    );
endinterface
`default_nettype wire

// File: rtl/noc_output_sink_fifo.sv
`default_nettype none
// ============================================================================
// Module   : axis_sync_fifo
// Brief    : First-word-fall-through synchronous FIFO with wrap-bit pointers
//            and an occupancy count. Head word reads as zero when empty.
// Revision : 1.0 - initial release
// ============================================================================
module axis_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  wire logic                     CLK,
    input  wire logic                     RST,
    input  wire logic                     push_i,
    input  wire logic [WIDTH-1:0]         din_i,
    input  wire logic                     pop_i,
    output logic      [WIDTH-1:0]         dout_o,
    output logic      [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             w_empty;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    // Full when the indices match but the wrap bits differ
    assign w_empty   = (wr_q == rd_q);
    assign w_full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign w_do_push = push_i && !w_full;
    assign w_do_pop  = pop_i && !w_empty;
    assign count_o   = wr_q - rd_q;
    assign dout_o    = w_empty ? '0 : mem_q[rd_q[AW-1:0]];

    // Pointer next-state
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (w_do_push) wr_d = wr_q + 1'b1;
        if (w_do_pop)  rd_d = rd_q + 1'b1;
    end

    // Pointer registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage array, no reset needed since empty head is masked
    always_ff @(posedge CLK) begin
        if (w_do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule
`default_nettype wire

// File: rtl/noc_output_sink.sv
`default_nettype none
// ============================================================================
// Module   : noc_output_sink
// Brief    : NoC endpoint sink. Buffers AXI-Stream flits in an FWFT FIFO,
//            tracks packet boundaries, counts completed packets per TID and
//            flags TID changes inside a packet.
//            Option macro NOC_OUTPUT_SINK_DEST_CHECK_EN: drop flits whose
//            TDEST differs from NODE_ID and count them in DROP_CNT.
// Revision : 1.0 - initial release
// ============================================================================
module noc_output_sink
    import noc_output_sink_pkg::*;
#(
    parameter int TDATAW  = 32,
    parameter int TDESTW  = 4,
    parameter int TIDW    = 2,
    parameter int DEPTH   = 8,
    parameter int CNTW    = 16,
    parameter int NODE_ID = 0
) (
    input  wire logic                         CLK,
    input  wire logic                         RST,
    noc_output_sink_if.slave                  s_axis,
    output logic                              OUT_VALID,
    input  wire logic                         OUT_READY,
    output logic [TDATAW-1:0]                 DATA_O,
    output logic                              OUT_LAST,
    output logic [TIDW-1:0]                   OUT_ID,
    output logic                              DONE,
    output logic [ids_of(TIDW)*CNTW-1:0]      PKT_CNT,
    output logic [$clog2(DEPTH):0]            LEVEL,
    output logic                              ERR_ID,
    output logic [CNTW-1:0]                   DROP_CNT
);
    localparam int NUM_IDS = ids_of(TIDW);
    localparam int LW      = $clog2(DEPTH) + 1;
    localparam int FW      = TDATAW + 1 + TIDW;

    logic [LW-1:0]                 w_level;
    logic                          w_accept;
    logic                          w_keep;
    logic                          w_push;
    logic                          w_pop;
    logic                          w_complete;
    logic                          w_tid_err;
    logic [FW-1:0]                 w_head;
    sink_state_e                   state_q, state_d;
    logic [TIDW-1:0]               tid_q, tid_d;
    logic [NUM_IDS-1:0][CNTW-1:0]  cnt_q, cnt_d;
    logic                          done_q;
    logic                          err_q;

    // Ready depends only on registered occupancy (and is held low in reset)
    assign s_axis.AXIS_S_TREADY = !RST && (w_level != LW'(DEPTH));
    assign w_accept   = s_axis.AXIS_S_TVALID && s_axis.AXIS_S_TREADY;
    assign w_push     = w_accept && w_keep;
    assign w_pop      = OUT_VALID && OUT_READY;
    assign w_complete = w_push && s_axis.AXIS_S_TLAST;

    axis_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .push_i  (w_push),
        .din_i   ({s_axis.AXIS_S_TDATA, s_axis.AXIS_S_TLAST, s_axis.AXIS_S_TID}),
        .pop_i   (w_pop),
        .dout_o  (w_head),
        .count_o (w_level)
    );

    assign LEVEL     = w_level;
    assign OUT_VALID = (w_level != '0);
    assign DATA_O    = w_head[FW-1 -: TDATAW];
    assign OUT_LAST  = w_head[TIDW];
    assign OUT_ID    = w_head[TIDW-1:0];

`ifdef NOC_OUTPUT_SINK_DEST_CHECK_EN
    logic [CNTW-1:0] drop_q;

    assign w_keep   = (s_axis.AXIS_S_TDEST == TDESTW'(NODE_ID));
    assign DROP_CNT = drop_q;

    // Saturating count of flits addressed to another node
    always_ff @(posedge CLK) begin
        if (RST) begin
            drop_q <= '0;
        end else if (w_accept && !w_keep && (drop_q != '1)) begin
            drop_q <= drop_q + 1'b1;
        end
    end
`else
    logic w_unused_dest;

    assign w_keep        = 1'b1;
    assign DROP_CNT      = '0;
    assign w_unused_dest = ^{s_axis.AXIS_S_TDEST, TDESTW'(NODE_ID)};
`endif

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            tid_q   <= '0;
        end else begin
            state_q <= state_d;
            tid_q   <= tid_d;
        end
    end

    // FSM next state: advances on every accepted flit, kept or dropped
    always_comb begin
        state_d = state_q;
        tid_d   = tid_q;
        if (w_accept) begin
            case (state_q)
                IDLE: begin
                    if (!s_axis.AXIS_S_TLAST) begin
                        state_d = IN_PKT;
                        tid_d   = s_axis.AXIS_S_TID;
                    end
                end
                IN_PKT: begin
                    if (s_axis.AXIS_S_TLAST) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: TID mismatch inside an open packet
    always_comb begin
        w_tid_err = 1'b0;
        if (state_q == IN_PKT && w_accept && (s_axis.AXIS_S_TID != tid_q)) begin
            w_tid_err = 1'b1;
        end
    end

    // Per-TID completed-packet counter next state (wraps naturally)
    always_comb begin
        cnt_d = cnt_q;
        if (w_complete) begin
            cnt_d[s_axis.AXIS_S_TID] = cnt_q[s_axis.AXIS_S_TID] + 1'b1;
        end
    end

    // Status registers: counters, DONE pulse, sticky ERR_ID
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= w_complete;
            err_q  <= err_q | w_tid_err;
        end
    end

    assign PKT_CNT = cnt_q;
    assign DONE    = done_q;
    assign ERR_ID  = err_q;

endmodule
`default_nettype wire
